wrapper_packet_deconstruct: RTL and testbench
=============================================

Name: wrapper_packet_deconstruct

Overview:
- Drains accelerator result packets from a valid/ready stream.
- Exposes each packet to the host as a window of 32-bit read-only registers.
- Holds up to two packets in a ping-pong buffer so the accelerator can keep producing while the host reads.
- A packet is released when the host reads its last register word. This mirrors, on the output side, the packet-from-register-writes path on the input side.

Parameters:
- ADDRWIDTH, 11, register address width (window of 2^ADDRWIDTH bytes).
- PACKETWIDTH, 512, packet width in bits; must be a power-of-two multiple of 32.

Ports:
- hclk  input  1  clock.
- hresetn  input  1  reset, asynchronous, active-low.
- addr  input  ADDRWIDTH  register byte address.
- read_en  input  1  register read strobe.
- write_en  input  1  register write strobe (ignored).
- byte_strobe  input  4  write byte enables (ignored).
- wdata  input  32  write data (ignored).
- rdata  output  32  read data.
- wready  output  1  write accept; constant 1.
- rready  output  1  read accept.
- packet_data  input  PACKETWIDTH  incoming packet.
- packet_data_last  input  1  last packet of accelerator output block.
- packet_data_valid  input  1  packet valid.
- packet_data_ready  output  1  packet accept.
- deconstructor_valid  output  1  at least one packet is buffered.
- deconstructor_last  output  1  last flag of the head packet.

Behaviour:
- Derived widths:
  - PACKETBYTEWIDTH = log2(PACKETWIDTH/8).
  - Word index = addr[PACKETBYTEWIDTH-1:2].
  - Word w occupies bits [w*32+31 : w*32].
  - Last word = word index all ones.
  - Upper address bits [ADDRWIDTH-1:PACKETBYTEWIDTH] are ignored; every packet-sized slice aliases the head packet.
- Storage:
  - Two PACKETWIDTH+1-bit entries (data plus last flag).
  - 1-bit write pointer, 1-bit read pointer, 2-bit count (0..2).
  - Reset: count=0, both pointers=0, entries cleared to 0.
- Push (input side):
  - packet_data_ready = (count != 2), from registered count only. It does not depend on a same-cycle pop.
  - A push occurs when valid and ready are both high. The packet and last flag are stored at the write pointer; the write pointer toggles.
  - The packet is visible to reads the following cycle.
- Read path:
  - rready = (count != 0). A read when count == 0 stalls.
  - rdata = head word selected by word index when read_en && rready; otherwise 0. This path is combinational, zero latency.
  - Reads do not modify data. Repeated reads of the same word return identical data.
- Pop:
  - Occurs when read_en && rready && last word (read handshake on the last word).
  - The read pointer toggles at the clock edge. The next read sees the next packet or stalls.
  - Reading words out of order is legal. Only the last-word read pops; reading the last word first discards the rest.
- Count update:
  - Push only: +1.
  - Pop only: -1.
  - Both in the same cycle (possible when count==1): count unchanged, pointers both toggle.
- Status outputs:
  - deconstructor_valid = (count != 0).
  - deconstructor_last = last flag of the head entry when count != 0, else 0.
- Writes:
  - No effect on any state. wready = 1 always, including during reset.
- Reset values of outputs:
  - rdata=0, rready=0, packet_data_ready=1, deconstructor_valid=0, deconstructor_last=0, wready=1.
- Reset mid-operation:
  - Buffered packets are discarded. Any in-flight input handshake is lost; the producer must re-send.
- Assertions (verification):
  - No push when count==2.
  - No pop when count==0.
  - count equals pushes minus pops at all times.

Test Plan:
- Reset then idle -> packet_data_ready=1, rready=0, deconstructor_valid=0, rdata=0 with read_en=1.
- Push one packet, word w = 32'hA000_0000+w, last=1, then read addr 0x00..0x3C in order -> rdata = 0xA0000000..0xA000000F. deconstructor_last=1 until the read of 0x3C; count then returns to 0 and rready falls.
- Push three back-to-back packets -> ready drops after the second push. Pop the first by reading 0x3C -> ready rises and the third is accepted. Reads return the packets in order 1, 2, 3.
- count==1 with simultaneous push and last-word read -> count stays 1, the next read at 0x00 returns word 0 of the new packet.
- Read 0x40 and 0x7C (aliasing) -> returns head words 0 and 15; the read of 0x7C pops.
- Write 32'hFFFFFFFF to 0x04 between reads -> wready=1, a subsequent read of 0x04 is unchanged. Assert hresetn low with count==2 -> count=0, rready=0 the same cycle.

Source files
------------

// File: rtl/wrapper_packet_deconstruct.sv
// Ping-pong result buffer: accepts packets from a valid/ready stream and exposes the head
// packet as a read-only window of 32-bit words; reading the last word releases the packet.
module wrapper_packet_deconstruct #(
   parameter int ADDRWIDTH   = 11,
   parameter int PACKETWIDTH = 512
) (
   input  logic                   hclk,
   input  logic                   hresetn,
   input  logic [ADDRWIDTH-1:0]   addr,
   input  logic                   read_en,
   input  logic                   write_en,
   input  logic [3:0]             byte_strobe,
   input  logic [31:0]            wdata,
   output logic [31:0]            rdata,
   output logic                   wready,
   output logic                   rready,
   input  logic [PACKETWIDTH-1:0] packet_data,
   input  logic                   packet_data_last,
   input  logic                   packet_data_valid,
   output logic                   packet_data_ready,
   output logic                   deconstructor_valid,
   output logic                   deconstructor_last
);
   localparam int PACKETBYTEWIDTH = $clog2(PACKETWIDTH / 8);
   localparam int NWORDS          = PACKETWIDTH / 32;
   localparam int WIDXW           = PACKETBYTEWIDTH - 2;

   typedef struct packed {
      logic                   last;
      logic [NWORDS-1:0][31:0] words;
   } entry_t;

   entry_t [1:0]     mem;
   entry_t           head;
   logic             wr_ptr, rd_ptr;
   logic [1:0]       count;
   logic [WIDXW-1:0] word_idx;
   logic             push, pop;

   // Upper address bits alias the head packet; writes are accepted and dropped.
   logic unused_ok;
   assign unused_ok = ^{write_en, byte_strobe, wdata,
                        addr[ADDRWIDTH-1:PACKETBYTEWIDTH], addr[1:0]};

   assign word_idx          = addr[PACKETBYTEWIDTH-1:2];
   assign head              = mem[rd_ptr];

   assign wready            = 1'b1;
   assign rready            = (count != 2'd0);
   assign packet_data_ready = (count != 2'd2);
   assign push              = packet_data_valid && packet_data_ready;
   assign pop               = read_en && rready && (&word_idx);

   assign rdata               = (read_en && rready) ? head.words[word_idx] : 32'd0;
   assign deconstructor_valid = rready;
   assign deconstructor_last  = rready & head.last;

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         mem    <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= {packet_data_last, packet_data};
            wr_ptr      <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         // Simultaneous push and pop leaves the occupancy unchanged.
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: tb/tb_wrapper_packet_deconstruct.sv
// Directed plus randomized bench for wrapper_packet_deconstruct against a packet-queue model.
module tb_wrapper_packet_deconstruct;
   logic         hclk = 1'b0;
   logic         hresetn = 1'b0;
   logic [10:0]  addr = '0;
   logic         read_en = 1'b0;
   logic         write_en = 1'b0;
   logic [3:0]   byte_strobe = '0;
   logic [31:0]  wdata = '0;
   logic [31:0]  rdata;
   logic         wready, rready;
   logic [511:0] packet_data = '0;
   logic         packet_data_last = 1'b0;
   logic         packet_data_valid = 1'b0;
   logic         packet_data_ready;
   logic         deconstructor_valid, deconstructor_last;

   wrapper_packet_deconstruct dut (
      .hclk(hclk), .hresetn(hresetn), .addr(addr), .read_en(read_en),
      .write_en(write_en), .byte_strobe(byte_strobe), .wdata(wdata),
      .rdata(rdata), .wready(wready), .rready(rready),
      .packet_data(packet_data), .packet_data_last(packet_data_last),
      .packet_data_valid(packet_data_valid), .packet_data_ready(packet_data_ready),
      .deconstructor_valid(deconstructor_valid), .deconstructor_last(deconstructor_last)
   );

   always #5 hclk = ~hclk;

   typedef struct {
      logic [511:0] d;
      logic         l;
   } pkt_t;

   pkt_t mq[$];
   int   passed = 0;
   int   total  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) begin
         passed = passed + 1;
      end else begin
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [511:0] rpkt();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Drive one cycle of inputs, check outputs against the queue model, then advance the model.
   task automatic step(input string tag, input bit rd, input logic [10:0] a,
                       input bit pv, input logic [511:0] pd, input bit pl, input bit wr);
      int           n;
      logic [511:0] hd;
      logic [31:0]  erd;
      logic [3:0]   w;
      bit           do_push, do_pop;
      read_en = rd; addr = a; packet_data_valid = pv; packet_data = pd;
      packet_data_last = pl; write_en = wr; byte_strobe = 4'hF;
      wdata = wr ? 32'hFFFF_FFFF : $urandom;
      #1;
      n   = mq.size();
      w   = a[5:2];
      erd = 32'd0;
      if (rd && n != 0) begin
         hd  = mq[0].d;
         erd = hd[w*32 +: 32];
      end
      chk({tag, ".rdata"}, rdata, erd);
      chk({tag, ".rready"}, {31'd0, rready}, {31'd0, n != 0});
      chk({tag, ".pready"}, {31'd0, packet_data_ready}, {31'd0, n != 2});
      chk({tag, ".dvalid"}, {31'd0, deconstructor_valid}, {31'd0, n != 0});
      chk({tag, ".dlast"}, {31'd0, deconstructor_last}, {31'd0, (n != 0) ? mq[0].l : 1'b0});
      chk({tag, ".wready"}, {31'd0, wready}, 32'd1);
      do_push = pv && (n < 2);
      do_pop  = rd && (n > 0) && (w == 4'hF);
      @(posedge hclk);
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back('{d: pd, l: pl});
      #1;
   endtask

   initial begin
      logic [511:0] pa, p1, p2, p3, p4, p5, z;
      logic [10:0]  ra;
      z = '0;
      for (int w = 0; w < 16; w++) pa[w*32 +: 32] = 32'hA000_0000 + w;
      p1 = rpkt(); p2 = rpkt(); p3 = rpkt(); p4 = rpkt(); p5 = rpkt();

      // Reset, reading while empty
      read_en = 1'b1;
      #2;
      chk("rst.pready", {31'd0, packet_data_ready}, 32'd1);
      chk("rst.rready", {31'd0, rready}, 32'd0);
      chk("rst.dvalid", {31'd0, deconstructor_valid}, 32'd0);
      chk("rst.rdata", rdata, 32'd0);
      chk("rst.wready", {31'd0, wready}, 32'd1);
      @(posedge hclk); #1;
      hresetn = 1'b1;
      step("idle", 1, 11'h000, 0, z, 0, 0);

      // Single packet read in order; the 0x3C read pops it
      step("pushA", 0, 11'h000, 1, pa, 1, 0);
      for (int w = 0; w < 16; w++) step("readA", 1, 11'(w * 4), 0, z, 0, 0);
      step("emptyA", 1, 11'h000, 0, z, 0, 0);

      // Back-to-back pushes with backpressure
      step("push1", 0, 11'h000, 1, p1, 0, 0);
      step("push2", 0, 11'h000, 1, p2, 1, 0);
      step("push3blk", 0, 11'h000, 1, p3, 0, 0);
      step("pop1", 1, 11'h03C, 1, p3, 0, 0);
      step("push3", 0, 11'h000, 1, p3, 0, 0);
      step("rd2w2", 1, 11'h008, 0, z, 0, 0);
      step("rd2w0", 1, 11'h000, 0, z, 0, 0);
      step("pop2", 1, 11'h03C, 0, z, 0, 0);
      step("pop3first", 1, 11'h03C, 0, z, 0, 0);
      step("stall", 1, 11'h004, 0, z, 0, 0);

      // Simultaneous push and pop at count 1
      step("push4", 0, 11'h000, 1, p4, 1, 0);
      step("swap45", 1, 11'h03C, 1, p5, 0, 0);
      step("rd5w0", 1, 11'h000, 0, z, 0, 0);
      step("alias40", 1, 11'h040, 0, z, 0, 0);
      step("alias7C", 1, 11'h07C, 0, z, 0, 0);
      step("aliasempty", 1, 11'h040, 0, z, 0, 0);

      // Writes have no effect
      step("pushW", 0, 11'h000, 1, pa, 0, 0);
      step("rdW1", 1, 11'h004, 0, z, 0, 0);
      step("write", 0, 11'h004, 0, z, 0, 1);
      step("rdW2", 1, 11'h004, 0, z, 0, 0);

      // Asynchronous reset with two packets buffered
      step("fill", 0, 11'h000, 1, p1, 1, 0);
      step("fill2", 0, 11'h000, 0, z, 0, 0);
      read_en = 1'b1; addr = 11'h000; packet_data_valid = 1'b0;
      hresetn = 1'b0;
      #1;
      mq.delete();
      chk("arst.rready", {31'd0, rready}, 32'd0);
      chk("arst.pready", {31'd0, packet_data_ready}, 32'd1);
      chk("arst.dvalid", {31'd0, deconstructor_valid}, 32'd0);
      chk("arst.dlast", {31'd0, deconstructor_last}, 32'd0);
      chk("arst.rdata", rdata, 32'd0);
      @(posedge hclk); #1;
      hresetn = 1'b1;
      step("postrst", 1, 11'h03C, 0, z, 0, 0);

      // Randomized traffic, biased toward last-word reads so packets drain
      for (int i = 0; i < 300; i++) begin
         ra = 11'($urandom);
         if ($urandom_range(0, 3) == 0) ra[5:2] = 4'hF;
         step("rand", bit'($urandom_range(0, 1)), ra, bit'($urandom_range(0, 1)),
              rpkt(), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
